// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues one READ command to a serial NOR flash
// after reset and then streams received bytes out with a one-cycle strobe.
module spi_flash_reader #(
   parameter logic [7:0]  READ_CMD       = 8'h03,
   parameter logic [23:0] START_ADDR     = 24'h000000,
   parameter int          CS_IDLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic       out_bit,
   input  logic       out,
   output logic [7:0] data_out_sim,
   output logic       chip_select,
   output logic       data_clk,
   output logic       data_ready,
   input  logic       rom_init_finished
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      READ,
      DONE
   } state_t;

   localparam logic [31:0] TX_WORD = {READ_CMD, START_ADDR};
   localparam int IW = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(CS_IDLE_CYCLES - 1);

   state_t        state, state_nx;
   logic [IW-1:0] idle_cnt, idle_nx;
   logic [4:0]    bit_cnt, cnt_nx;
   logic [31:0]   tx, tx_nx;
   logic [6:0]    rx, rx_nx;
   logic          sclk_nx;
   logic          mosi_nx;
   logic          cs_nx;
   logic [7:0]    dout_nx;
   logic          rdy_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         idle_cnt     <= '0;
         bit_cnt      <= '0;
         tx           <= '0;
         rx           <= '0;
         data_clk     <= 1'b0;
         out_bit      <= 1'b0;
         chip_select  <= 1'b1;
         data_out_sim <= 8'h00;
         data_ready   <= 1'b0;
      end else begin
         state        <= state_nx;
         idle_cnt     <= idle_nx;
         bit_cnt      <= cnt_nx;
         tx           <= tx_nx;
         rx           <= rx_nx;
         data_clk     <= sclk_nx;
         out_bit      <= mosi_nx;
         chip_select  <= cs_nx;
         data_out_sim <= dout_nx;
         data_ready   <= rdy_nx;
      end
   end

   // SCK low phase: stop may end the transfer before the bit starts.
   // SCK high phase: the next edge samples MISO and shifts MOSI.
   always_comb begin
      state_nx = state;
      idle_nx  = idle_cnt;
      cnt_nx   = bit_cnt;
      tx_nx    = tx;
      rx_nx    = rx;
      sclk_nx  = data_clk;
      mosi_nx  = out_bit;
      cs_nx    = chip_select;
      dout_nx  = data_out_sim;
      rdy_nx   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rom_init_finished) begin
               state_nx = DONE;
            end else if (idle_cnt == IDLE_LAST) begin
               cs_nx    = 1'b0;
               mosi_nx  = TX_WORD[31];
               tx_nx    = TX_WORD << 1;
               cnt_nx   = 5'd0;
               state_nx = CMD;
            end else begin
               idle_nx = idle_cnt + IW'(1);
            end
         end
         CMD, ADDR, READ: begin
            if (!data_clk) begin
               if (rom_init_finished) begin
                  state_nx = DONE;
                  cs_nx    = 1'b1;
                  mosi_nx  = 1'b0;
               end else begin
                  sclk_nx = 1'b1;
               end
            end else begin
               sclk_nx = 1'b0;
               mosi_nx = tx[31];
               tx_nx   = tx << 1;
               cnt_nx  = bit_cnt + 5'd1;
               if (state == READ) begin
                  rx_nx = {rx[5:0], out};
                  if (bit_cnt[2:0] == 3'd7) begin
                     dout_nx = {rx, out};
                     rdy_nx  = 1'b1;
                  end
               end
               if (state == CMD && bit_cnt == 5'd7) begin
                  state_nx = ADDR;
               end
               if (state == ADDR && bit_cnt == 5'd31) begin
                  state_nx = READ;
               end
               if (rom_init_finished) begin
                  state_nx = DONE;
                  cs_nx    = 1'b1;
                  mosi_nx  = 1'b0;
               end
            end
         end
         DONE: begin
            cs_nx   = 1'b1;
            sclk_nx = 1'b0;
            mosi_nx = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            cs_nx    = 1'b1;
            sclk_nx  = 1'b0;
            mosi_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash model.
module tb_spi_flash_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       out_bit;
   logic       so;
   logic [7:0] data_out_sim;
   logic       chip_select;
   logic       data_clk;
   logic       data_ready;
   logic       stop;

   spi_flash_reader dut (
      .clk               (clk),
      .reset             (reset),
      .out_bit           (out_bit),
      .out               (so),
      .data_out_sim      (data_out_sim),
      .chip_select       (chip_select),
      .data_clk          (data_clk),
      .data_ready        (data_ready),
      .rom_init_finished (stop)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [64];

   // flash model, evaluated mid-cycle on SCK transitions
   logic        sclk_q = 1'b0;
   logic [31:0] cmd_sh = '0;
   logic [31:0] cmd_word = '0;
   int          cmd_cnt = 0;
   int          in_bits = 0;
   int          out_bits = 0;
   int          cs_viol = 0;

   initial so = 1'b0;

   always @(negedge clk) begin
      if (chip_select) begin
         in_bits  <= 0;
         out_bits <= 0;
         so       <= 1'b0;
         if (data_clk) cs_viol <= cs_viol + 1;
      end else if (data_clk && !sclk_q) begin
         if (in_bits < 32) begin
            cmd_sh  <= {cmd_sh[30:0], out_bit};
            in_bits <= in_bits + 1;
            if (in_bits == 31) begin
               cmd_word <= {cmd_sh[30:0], out_bit};
               cmd_cnt  <= cmd_cnt + 1;
            end
         end
      end else if (!data_clk && sclk_q && in_bits >= 32) begin
         so <= mem[(int'(cmd_word[5:0]) + out_bits / 8) % 64][7 - out_bits % 8];
         out_bits <= out_bits + 1;
      end
      sclk_q <= data_clk;
   end

   // strobe and chip-select monitor
   logic [7:0] sq_data [$];
   int         sq_cyc [$];
   logic       rdy_q = 1'b0;
   logic       cs_q = 1'b1;
   int         wide_cnt = 0;
   int         cs_falls = 0;
   int         cs_fall_cyc = 0;

   always @(negedge clk) begin
      if (data_ready) begin
         sq_data.push_back(data_out_sim);
         sq_cyc.push_back(cyc);
      end
      if (data_ready && rdy_q) wide_cnt <= wide_cnt + 1;
      if (cs_q && !chip_select) begin
         cs_falls    <= cs_falls + 1;
         cs_fall_cyc <= cyc;
      end
      rdy_q <= data_ready;
      cs_q  <= chip_select;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outs(input string name);
      chk(name, {19'd0, chip_select, data_clk, out_bit, data_ready,
                 data_out_sim}, {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
   endtask

   task automatic wait_strobes(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sq_data.size() >= n) break;
         @(negedge clk);
      end
      chk("strobe_wait", (sq_data.size() >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [7:0] data;
      int         gap;
   } vec_t;

   vec_t vec [6];
   int   b;
   int   rel_cyc;
   int   cmd0;
   int   f0;
   int   n0;
   int   cnt;
   int   errs;
   logic acc;

   initial begin
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      mem[2] = 8'hFF;
      mem[3] = 8'h00;
      for (int i = 4; i < 64; i++) mem[i] = 8'(i * 37 + 11);
      vec[0] = '{8'hA5, 80};
      vec[1] = '{8'h3C, 16};
      vec[2] = '{8'hFF, 16};
      vec[3] = '{8'h00, 16};
      vec[4] = '{8'h9F, 16};
      vec[5] = '{8'hC4, 16};

      reset = 1'b0;
      stop  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk_reset_outs("reset_hold");
      end

      // release: CS timing, command word, first bytes
      reset   = 1'b1;
      rel_cyc = cyc;
      cmd0    = cmd_cnt;
      repeat (3) @(negedge clk);
      chk("cs_idle_hold", {31'd0, chip_select}, 32'd1);
      @(negedge clk);
      chk("cs_assert", {31'd0, chip_select}, 32'd0);
      chk("mosi_bit31", {31'd0, out_bit}, 32'd0);
      @(negedge clk);
      chk("cs_fall_delay", cs_fall_cyc - rel_cyc, 32'd4);
      b = sq_data.size();
      wait_strobes(b + 6, 300);
      chk("cmd_word", cmd_word, 32'h0300_0000);
      chk("cmd_count", cmd_cnt - cmd0, 32'd1);
      for (int i = 0; i < 6; i++) begin
         if (b + i < sq_data.size()) begin
            chk($sformatf("byte%0d", i), {24'd0, sq_data[b + i]},
                {24'd0, vec[i].data});
            if (i == 0)
               chk("first_lat", sq_cyc[b] - cs_fall_cyc, vec[0].gap);
            else
               chk($sformatf("gap%0d", i), sq_cyc[b + i] - sq_cyc[b + i - 1],
                   vec[i].gap);
         end
      end
      chk("strobe_width", wide_cnt, 32'd0);
      chk("sck_cs_high", cs_viol, 32'd0);

      // reset during the fifth byte, then restart
      reset = 1'b0;
      #1;
      chk_reset_outs("reset_async");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cmd0  = cmd_cnt;
      b     = sq_data.size();
      wait_strobes(b + 4, 250);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_outs("reset_mid_byte");
      chk("no_fifth_byte", sq_data.size() - b, 32'd4);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      b     = sq_data.size();
      wait_strobes(b + 1, 150);
      chk("restart_cmd_count", cmd_cnt - cmd0, 32'd2);
      chk("restart_cmd", cmd_word, 32'h0300_0000);
      if (b < sq_data.size())
         chk("restart_byte0", {24'd0, sq_data[b]}, {24'd0, mem[0]});

      // stop mid-byte
      wait_strobes(b + 3, 100);
      repeat (6) @(negedge clk);
      stop = 1'b1;
      n0   = sq_data.size();
      f0   = cs_falls;
      repeat (2) @(negedge clk);
      chk("stop_cs_high", {31'd0, chip_select}, 32'd1);
      acc = 1'b0;
      repeat (40) begin
         @(negedge clk);
         acc = acc | data_clk;
      end
      stop = 1'b0;
      repeat (40) begin
         @(negedge clk);
         acc = acc | data_clk | chip_select === 1'b0;
      end
      chk("stop_sck_idle", {31'd0, acc}, 32'd0);
      chk("stop_no_strobe", sq_data.size() - n0, 32'd0);
      chk("stop_no_restart", cs_falls - f0, 32'd0);
      chk("stop_outs", {29'd0, chip_select, data_clk, out_bit}, 32'd4);

      // stop already high at reset release: CS never asserts
      stop  = 1'b1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      f0    = cs_falls;
      repeat (20) @(negedge clk);
      chk("idle_stop_no_cs", cs_falls - f0, 32'd0);
      chk("idle_stop_cs", {31'd0, chip_select}, 32'd1);
      stop = 1'b0;

      // scaled bulk load of 48 bytes
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      b     = sq_data.size();
      for (int i = 0; i < 1200; i++) begin
         if (sq_data.size() - b >= 48) break;
         @(negedge clk);
      end
      stop = 1'b1;
      repeat (40) @(negedge clk);
      stop = 1'b0;
      cnt  = sq_data.size() - b;
      chk("load_count", (cnt == 48 || cnt == 49) ? 32'd1 : 32'd0, 32'd1);
      errs = 0;
      for (int i = 0; i < 48 && b + i < sq_data.size(); i++) begin
         if (sq_data[b + i] !== mem[i]) errs++;
      end
      chk("load_data", errs, 32'd0);
      chk("load_width", wide_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
